// File: rtl/wb_pkg.sv
// Shared constants and payload types for the write-back arbiter.
package wb_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned AW_DEF   = 5;

  // One pending register-file write: destination index and data.
  typedef struct packed {
    logic [AW_DEF-1:0]   rd;
    logic [XLEN_DEF-1:0] wd;
  } wb_req_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between upstream producers (ALU/LSU/decode) and the write-back arbiter.
interface wb_arbiter_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
);
  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_wd;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [AW-1:0]   lsu_rd;
  logic [XLEN-1:0] lsu_wd;
  logic            rf_we;
  logic [AW-1:0]   rf_rd;
  logic [XLEN-1:0] rf_wd;
  logic            stall;
  logic [AW-1:0]   chk_rs;
  logic            chk_hit;
  logic            ovf_err;

  modport master (
    output alu_valid, alu_rd, alu_wd, lsu_valid, lsu_rd, lsu_wd, chk_rs,
    input  lsu_ready, rf_we, rf_rd, rf_wd, stall, chk_hit, ovf_err
  );

  modport slave (
    input  alu_valid, alu_rd, alu_wd, lsu_valid, lsu_rd, lsu_wd, chk_rs,
    output lsu_ready, rf_we, rf_rd, rf_wd, stall, chk_hit, ovf_err
  );
endinterface

// File: rtl/wb_fifo.sv
// Circular buffer for load results; exposes per-entry valid+rd for hazard lookup.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      push,
  input  logic [AW-1:0]             push_rd,
  input  logic [XLEN-1:0]           push_wd,
  input  logic                      pop,
  output logic [AW-1:0]             head_rd,
  output logic [XLEN-1:0]           head_wd,
  output logic                      empty,
  output logic                      full,
  output logic [DEPTH-1:0]          ent_valid,
  output logic [DEPTH-1:0][AW-1:0]  ent_rd
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][AW-1:0]   rd_mem_q, rd_mem_d;
  logic [DEPTH-1:0][XLEN-1:0] wd_mem_q, wd_mem_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              count_q, count_d;

  // Next-state: write at tail, advance head, track occupancy.
  always_comb begin
    rd_mem_d = rd_mem_q;
    wd_mem_d = wd_mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      rd_mem_d[wr_ptr_q] = push_rd;
      wd_mem_d[wr_ptr_q] = push_wd;
      wr_ptr_d           = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // State registers; reset drops all queued entries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_mem_q <= '0;
      wd_mem_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_mem_q <= rd_mem_d;
      wd_mem_q <= wd_mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // An entry is live when its distance from the head is below the count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PW-1:0] off;
    assign off          = PW'(i) - rd_ptr_q;
    assign ent_valid[i] = ({1'b0, off} < (PW + 1)'(count_q));
  end

  assign ent_rd  = rd_mem_q;
  assign head_rd = rd_mem_q[rd_ptr_q];
  assign head_wd = wd_mem_q[rd_ptr_q];
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: ALU has priority, loads buffered in wb_fifo, one registered RF write per cycle.
// Optional feature macro: WB_BYPASS_EN (empty FIFO + no ALU write lets a load go straight to the output register).
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  wb_arbiter_if.slave  bus
);

  logic                     alu_wr;
  logic                     lsu_ready_c;
  logic                     lsu_keep;
  logic                     bypass;
  logic                     push;
  logic                     pop;
  logic [AW-1:0]            head_rd;
  logic [XLEN-1:0]          head_wd;
  logic                     empty;
  logic                     full;
  logic [DEPTH-1:0]         ent_valid;
  logic [DEPTH-1:0][AW-1:0] ent_rd;
  logic                     fifo_hit;

  logic                     rf_we_q, rf_we_d;
  logic [AW-1:0]            rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]          rf_wd_q, rf_wd_d;
  logic                     ovf_err_q, ovf_err_d;

  assign alu_wr      = bus.alu_valid && (bus.alu_rd != '0);
  assign lsu_ready_c = reset_n && !full;
  assign lsu_keep    = bus.lsu_valid && lsu_ready_c && (bus.lsu_rd != '0);

`ifdef WB_BYPASS_EN
  assign bypass = lsu_keep && empty && !alu_wr;
`else
  assign bypass = 1'b0;
`endif

  assign push = lsu_keep && !bypass;
  assign pop  = !alu_wr && !empty;

  wb_fifo #(
    .XLEN  (XLEN),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_rd   (bus.lsu_rd),
    .push_wd   (bus.lsu_wd),
    .pop       (pop),
    .head_rd   (head_rd),
    .head_wd   (head_wd),
    .empty     (empty),
    .full      (full),
    .ent_valid (ent_valid),
    .ent_rd    (ent_rd)
  );

  // Output register select: ALU, then FIFO head, then bypassed load; idle keeps rd/wd.
  always_comb begin
    rf_we_d   = 1'b0;
    rf_rd_d   = rf_rd_q;
    rf_wd_d   = rf_wd_q;
    ovf_err_d = ovf_err_q | (alu_wr & full);
    if (alu_wr) begin
      rf_we_d = 1'b1;
      rf_rd_d = bus.alu_rd;
      rf_wd_d = bus.alu_wd;
    end else if (pop) begin
      rf_we_d = 1'b1;
      rf_rd_d = head_rd;
      rf_wd_d = head_wd;
    end else if (bypass) begin
      rf_we_d = 1'b1;
      rf_rd_d = bus.lsu_rd;
      rf_wd_d = bus.lsu_wd;
    end
  end

  // Output and sticky error registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_we_q   <= 1'b0;
      rf_rd_q   <= '0;
      rf_wd_q   <= '0;
      ovf_err_q <= 1'b0;
    end else begin
      rf_we_q   <= rf_we_d;
      rf_rd_q   <= rf_rd_d;
      rf_wd_q   <= rf_wd_d;
      ovf_err_q <= ovf_err_d;
    end
  end

  // Hazard lookup against live FIFO entries.
  always_comb begin
    fifo_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_rd[i] == bus.chk_rs)) begin
        fifo_hit = 1'b1;
      end
    end
  end

  assign bus.chk_hit   = (bus.chk_rs != '0) &&
                         (fifo_hit || (rf_we_q && (rf_rd_q == bus.chk_rs)));
  assign bus.lsu_ready = lsu_ready_c;
  assign bus.stall     = full;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_rd     = rf_rd_q;
  assign bus.rf_wd     = rf_wd_q;
  assign bus.ovf_err   = ovf_err_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (expectations follow WB_BYPASS_EN when defined).
module tb_wb_arbiter;
  import wb_pkg::*;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;

  wb_arbiter_if #(.XLEN(32), .AW(5)) bus ();

  wb_arbiter #(.XLEN(32), .AW(5), .DEPTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_wd    = '0;
    bus.lsu_valid = 1'b0;
    bus.lsu_rd    = '0;
    bus.lsu_wd    = '0;
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    bus.chk_rs = 5'd5;
    idle();
    #3;
    n_cmp++; if (bus.lsu_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready got=%b exp=0", bus.lsu_ready); end
    n_cmp++; if (bus.rf_we !== 1'b0) begin n_bad++; $display("FAIL rst_we got=%b exp=0", bus.rf_we); end
    n_cmp++; if (bus.rf_rd !== 5'd0 || bus.rf_wd !== 32'd0) begin n_bad++; $display("FAIL rst_rdwd got=%h/%h exp=0/0", bus.rf_rd, bus.rf_wd); end
    n_cmp++; if (bus.ovf_err !== 1'b0 || bus.stall !== 1'b0 || bus.chk_hit !== 1'b0) begin n_bad++; $display("FAIL rst_flags got=%b%b%b exp=000", bus.ovf_err, bus.stall, bus.chk_hit); end
    @(posedge clk); @(posedge clk); @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_cmp++; if (bus.lsu_ready !== 1'b1) begin n_bad++; $display("FAIL rel_ready got=%b exp=1", bus.lsu_ready); end
    tick();
  endtask

  task automatic test_alu();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_wd = 32'hDEADBEEF;
    tick();
    idle();
    n_cmp++; if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd3 || bus.rf_wd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL alu_write got=%b/%0d/%h exp=1/3/deadbeef", bus.rf_we, bus.rf_rd, bus.rf_wd); end
    tick();
    n_cmp++; if (bus.rf_we !== 1'b0 || bus.rf_rd !== 5'd3 || bus.rf_wd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL alu_idle got=%b/%0d/%h exp=0/3/deadbeef", bus.rf_we, bus.rf_rd, bus.rf_wd); end
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_wd = 32'h11111111;
    tick();
    idle();
    n_cmp++; if (bus.rf_we !== 1'b0 || bus.rf_wd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL alu_rd0 got=%b/%h exp=0/deadbeef", bus.rf_we, bus.rf_wd); end
  endtask

  task automatic test_load();
    logic e1;
    logic e2;
`ifdef WB_BYPASS_EN
    e1 = 1'b1; e2 = 1'b0;
`else
    e1 = 1'b0; e2 = 1'b1;
`endif
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd5; bus.lsu_wd = 32'h1234;
    #1;
    n_cmp++; if (bus.lsu_ready !== 1'b1) begin n_bad++; $display("FAIL load_ready got=%b exp=1", bus.lsu_ready); end
    tick();
    idle();
    n_cmp++; if (bus.rf_we !== e1 || (e1 && bus.rf_rd !== 5'd5)) begin n_bad++; $display("FAIL load_c1 got=%b/%0d exp=%b/5", bus.rf_we, bus.rf_rd, e1); end
    tick();
    n_cmp++; if (bus.rf_we !== e2 || bus.rf_rd !== 5'd5 || bus.rf_wd !== 32'h1234) begin n_bad++; $display("FAIL load_c2 got=%b/%0d/%h exp=%b/5/1234", bus.rf_we, bus.rf_rd, bus.rf_wd, e2); end
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_wd = 32'h9999;
    tick();
    idle();
    tick();
    tick();
    n_cmp++; if (bus.rf_we !== 1'b0 || bus.rf_wd !== 32'h1234) begin n_bad++; $display("FAIL load_rd0 got=%b/%h exp=0/1234", bus.rf_we, bus.rf_wd); end
  endtask

  task automatic test_back_to_back();
    wb_req_t req;
    int      lat;
    int      idx;
`ifdef WB_BYPASS_EN
    lat = 0;
`else
    lat = 1;
`endif
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin
        req.rd = 5'(16 + k);
        req.wd = 32'hD000_0000 + 32'(k);
        bus.lsu_valid = 1'b1; bus.lsu_rd = req.rd; bus.lsu_wd = req.wd;
        #1;
        n_cmp++; if (bus.lsu_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready k=%0d got=%b exp=1", k, bus.lsu_ready); end
      end else begin
        idle();
      end
      tick();
      idx = k - lat;
      if (idx >= 0 && idx < 3) begin
        n_cmp++; if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'(16 + idx) || bus.rf_wd !== 32'hD000_0000 + 32'(idx)) begin n_bad++; $display("FAIL b2b_out k=%0d got=%b/%0d/%h exp=1/%0d", k, bus.rf_we, bus.rf_rd, bus.rf_wd, 16 + idx); end
      end else begin
        n_cmp++; if (bus.rf_we !== 1'b0) begin n_bad++; $display("FAIL b2b_idle k=%0d got=%b exp=0", k, bus.rf_we); end
      end
    end
    idle();
    tick();
  endtask

  task automatic test_contention();
    int alu_t[12]  = '{10, 11, 12, 13, 0, 14, 0, 15, 0, 0, 0, 0};
    int lsu_t[12]  = '{20, 21, 22, 23, 24, 24, 0, 0, 0, 0, 0, 0};
    int rdy_t[12]  = '{1, 1, 1, 1, 0, 1, 0, 1, 1, 1, 1, 1};
    int out_t[12]  = '{10, 11, 12, 13, 20, 14, 21, 15, 22, 23, 24, 24};
    logic [31:0] ew;
    for (int c = 0; c < 12; c++) begin
      bus.alu_valid = (alu_t[c] != 0);
      bus.alu_rd    = 5'(alu_t[c]);
      bus.alu_wd    = 32'hA000_0000 + 32'(alu_t[c] - 10);
      bus.lsu_valid = (lsu_t[c] != 0);
      bus.lsu_rd    = 5'(lsu_t[c]);
      bus.lsu_wd    = 32'hB000_0000 + 32'(lsu_t[c] - 20);
      #1;
      n_cmp++; if (bus.lsu_ready !== 1'(rdy_t[c]) || bus.stall !== !1'(rdy_t[c])) begin n_bad++; $display("FAIL cont_flow c=%0d got=%b/%b exp=%0d/%0d", c, bus.lsu_ready, bus.stall, rdy_t[c], 1 - rdy_t[c]); end
      tick();
      ew = (out_t[c] >= 20) ? 32'hB000_0000 + 32'(out_t[c] - 20) : 32'hA000_0000 + 32'(out_t[c] - 10);
      n_cmp++; if (bus.rf_we !== (c != 11) || bus.rf_rd !== 5'(out_t[c]) || bus.rf_wd !== ew) begin n_bad++; $display("FAIL cont_out c=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, bus.rf_we, bus.rf_rd, bus.rf_wd, c != 11, out_t[c], ew); end
    end
    idle();
    n_cmp++; if (bus.ovf_err !== 1'b0) begin n_bad++; $display("FAIL cont_ovf got=%b exp=0", bus.ovf_err); end
  endtask

  task automatic test_hazard();
    bus.chk_rs = 5'd7;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_wd = 32'h99;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_wd = 32'h77;
    #1;
    n_cmp++; if (bus.chk_hit !== 1'b0) begin n_bad++; $display("FAIL haz_pre got=%b exp=0", bus.chk_hit); end
    tick();
    bus.alu_rd = 5'd8; bus.alu_wd = 32'h88; bus.lsu_valid = 1'b0;
    #1;
    n_cmp++; if (bus.chk_hit !== 1'b1 || bus.rf_rd !== 5'd9) begin n_bad++; $display("FAIL haz_q1 got=%b/%0d exp=1/9", bus.chk_hit, bus.rf_rd); end
    tick();
    idle();
    #1;
    n_cmp++; if (bus.chk_hit !== 1'b1 || bus.rf_rd !== 5'd8) begin n_bad++; $display("FAIL haz_q2 got=%b/%0d exp=1/8", bus.chk_hit, bus.rf_rd); end
    tick();
    n_cmp++; if (bus.chk_hit !== 1'b1 || bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd7 || bus.rf_wd !== 32'h77) begin n_bad++; $display("FAIL haz_commit got=%b/%b/%0d/%h exp=1/1/7/77", bus.chk_hit, bus.rf_we, bus.rf_rd, bus.rf_wd); end
    bus.chk_rs = 5'd0;
    #1;
    n_cmp++; if (bus.chk_hit !== 1'b0) begin n_bad++; $display("FAIL haz_rs0 got=%b exp=0", bus.chk_hit); end
    bus.chk_rs = 5'd7;
    tick();
    n_cmp++; if (bus.chk_hit !== 1'b0 || bus.rf_we !== 1'b0) begin n_bad++; $display("FAIL haz_clear got=%b/%b exp=0/0", bus.chk_hit, bus.rf_we); end
  endtask

  task automatic test_overflow();
    for (int c = 0; c < 4; c++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_wd = 32'(c);
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'(2 + c); bus.lsu_wd = 32'hC0 + 32'(c);
      tick();
    end
    idle();
    #1;
    n_cmp++; if (bus.stall !== 1'b1 || bus.lsu_ready !== 1'b0 || bus.ovf_err !== 1'b0) begin n_bad++; $display("FAIL ovf_full got=%b/%b/%b exp=1/0/0", bus.stall, bus.lsu_ready, bus.ovf_err); end
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd6; bus.alu_wd = 32'h66;
    tick();
    idle();
    n_cmp++; if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd6 || bus.rf_wd !== 32'h66 || bus.ovf_err !== 1'b1) begin n_bad++; $display("FAIL ovf_set got=%b/%0d/%h/%b exp=1/6/66/1", bus.rf_we, bus.rf_rd, bus.rf_wd, bus.ovf_err); end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++; if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'(2 + c) || bus.rf_wd !== 32'hC0 + 32'(c) || bus.ovf_err !== 1'b1) begin n_bad++; $display("FAIL ovf_drain c=%0d got=%b/%0d/%h/%b exp=1/%0d", c, bus.rf_we, bus.rf_rd, bus.rf_wd, bus.ovf_err, 2 + c); end
    end
    tick();
    n_cmp++; if (bus.rf_we !== 1'b0 || bus.ovf_err !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got=%b/%b exp=0/1", bus.rf_we, bus.ovf_err); end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_wd = 32'h10 + 32'(c);
      bus.lsu_valid = 1'b1; bus.lsu_rd = 5'(11 + c); bus.lsu_wd = 32'hE0 + 32'(c);
      tick();
    end
    idle();
    bus.chk_rs = 5'd12;
    #1;
    n_cmp++; if (bus.chk_hit !== 1'b1) begin n_bad++; $display("FAIL rmid_queued got=%b exp=1", bus.chk_hit); end
    #1;
    reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.rf_we !== 1'b0 || bus.lsu_ready !== 1'b0 || bus.ovf_err !== 1'b0) begin n_bad++; $display("FAIL rmid_rst got=%b/%b/%b exp=0/0/0", bus.rf_we, bus.lsu_ready, bus.ovf_err); end
    n_cmp++; if (bus.chk_hit !== 1'b0 || bus.stall !== 1'b0) begin n_bad++; $display("FAIL rmid_flags got=%b/%b exp=0/0", bus.chk_hit, bus.stall); end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    n_cmp++; if (bus.lsu_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_ready got=%b exp=1", bus.lsu_ready); end
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++; if (bus.rf_we !== 1'b0 || bus.chk_hit !== 1'b0) begin n_bad++; $display("FAIL rmid_nowrite c=%0d got=%b/%b exp=0/0", c, bus.rf_we, bus.chk_hit); end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_alu();
    test_load();
    test_back_to_back();
    test_contention();
    test_hazard();
    test_overflow();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
